// File: rtl/t07_fetch_queue.sv
// t07_fetch_queue: instruction prefetch queue in front of a busy-handshake memory.
// Keeps at most one fetch outstanding, retries addresses that return the
// INVALID_WORD sentinel, and presents fetched words show-ahead to the consumer.
//
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   mem_req, mem_addr          one-cycle request pulse, address held until completion
//   mem_busy, mem_rdata        memory busy flag, word returned in the completion cycle
//   redirect, redirect_pc      flush the queue and restart fetching at redirect_pc
//   instr_ready                consumer pop
//   instr_valid, instr_out,
//   pc_out, count              head entry (zero when empty) and occupancy
module t07_fetch_queue #(
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DEPTH        = 4,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter logic [DATA_W-1:0] INVALID_WORD = DATA_W'(32'hDEADBEEF)
) (
    input  logic                       clk,
    input  logic                       nrst,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_busy,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       instr_ready,
    output logic                       instr_valid,
    output logic [DATA_W-1:0]          instr_out,
    output logic [ADDR_W-1:0]          pc_out,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    // Registered state
    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic              prev_busy;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    entry_t            store [DEPTH];

    // Next-state values
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic              mem_req_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [CNT_W-1:0]  count_d;
    logic              instr_valid_d;
    entry_t            head_d;

    logic              completion;
    logic              push;
    logic              pop;
    logic              flush;
    entry_t            push_entry;

    assign completion = prev_busy & ~mem_busy;
    assign push_entry = '{instr: mem_rdata, pc: mem_addr};

    // Fetch control: request issue, completion handling, redirect
    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                end else if (count < CNT_W'(DEPTH)) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                    // A response arriving with the redirect is dropped here;
                    // waiting for another one in DRAIN would never end.
                    state_d    = completion ? IDLE : DRAIN;
                end else if (completion) begin
                    state_d = IDLE;
                    if (mem_rdata != INVALID_WORD) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc + ADDR_W'(4);
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (completion) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Queue bookkeeping; a flush wins over any pop or push in the same cycle
    always_comb begin
        pop           = (count != '0) && instr_ready && !flush;
        rd_ptr_d      = rd_ptr;
        wr_ptr_d      = wr_ptr;
        count_d       = count;
        instr_valid_d = 1'b0;
        head_d        = '0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr + PTR_W'(pop);
            wr_ptr_d = wr_ptr + PTR_W'(push);
            case ({push, pop})
                2'b10:   count_d = count + CNT_W'(1);
                2'b01:   count_d = count - CNT_W'(1);
                default: count_d = count;
            endcase
        end
        instr_valid_d = (count_d != '0);
        // The new head may be the word being written this cycle (queue was
        // empty, or its only entry is popped); bypass it from the memory bus.
        if (count_d != '0) begin
            if (push && (wr_ptr == rd_ptr_d)) begin
                head_d = push_entry;
            end else begin
                head_d = store[rd_ptr_d];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            prev_busy   <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            pc_out      <= '0;
        end else begin
            state       <= state_d;
            fetch_pc    <= fetch_pc_d;
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
            prev_busy   <= mem_busy;
            rd_ptr      <= rd_ptr_d;
            wr_ptr      <= wr_ptr_d;
            count       <= count_d;
            instr_valid <= instr_valid_d;
            instr_out   <= head_d.instr;
            pc_out      <= head_d.pc;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: tb/tb_t07_fetch_queue.sv
// tb_t07_fetch_queue: directed bench for t07_fetch_queue with a busy-handshake
// memory model, a request logger and a scoreboard monitor on consumer pops.
module tb_t07_fetch_queue;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        nrst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_busy;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [2:0]  count;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    int          checks;
    int          errors;
    int          inv_target;
    int          inv_served;
    localparam logic [31:0] INV_ADDR = 32'h8;

    t07_fetch_queue dut (
        .clk         (clk),
        .nrst        (nrst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_busy    (mem_busy),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: addr 8 holds 0x00100093, 0 holds 0x13, others derived from addr
    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h8) return 32'h00100093;
        return {a[19:0], 12'h013};
    endfunction

    function automatic logic [31:0] log_at(input int idx);
        if (idx < req_log.size()) return req_log[idx];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_one();
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
    endtask

    // Memory model: busy for LAT cycles after a request, word on the falling busy
    initial begin : mem_model
        logic [31:0] a;
        logic [31:0] w;
        logic        aborted;
        mem_busy   = 1'b0;
        mem_rdata  = '0;
        inv_served = 0;
        forever begin
            @(posedge clk); #1;
            mem_rdata = '0;
            if (nrst && mem_req) begin
                a = mem_addr;
                if (a == INV_ADDR && inv_served < inv_target) begin
                    w = 32'hDEADBEEF;
                    inv_served++;
                end else begin
                    w = word_of(a);
                end
                mem_busy = 1'b1;
                aborted  = 1'b0;
                for (int i = 0; i < LAT && !aborted; i++) begin
                    @(posedge clk); #1;
                    if (!nrst) aborted = 1'b1;
                end
                mem_busy = 1'b0;
                if (!aborted) mem_rdata = w;
            end
        end
    end

    initial begin : main
        exp_t e;
        int   n;
        int   base;
        checks      = 0;
        errors      = 0;
        inv_target  = 0;
        nrst        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;

        // Request logger and scoreboard monitor, sampled on the falling edge
        fork
            forever begin
                @(negedge clk);
                if (nrst && mem_req) req_log.push_back(mem_addr);
                if (nrst && instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got pc %0h, expected no pop", pc_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_instr", 64'(instr_out), 64'(e.instr));
                        check("pop_pc", 64'(pc_out), 64'(e.pc));
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr_out), 64'd0);
        check("rst_pc", 64'(pc_out), 64'd0);

        // First fetch: request on the first edge, valid one cycle after completion
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("first_req", 64'(mem_req), 64'd1);
        check("first_addr", 64'(mem_addr), 64'd0);
        n = 1;
        while (!instr_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_latency", 64'(n), 64'd4);
        check("first_instr", 64'(instr_out), 64'h13);
        check("first_pc", 64'(pc_out), 64'd0);
        e = '{instr: 32'h13, pc: 32'h0};
        exp_q.push_back(e);

        // Consumer held off: queue fills, no fifth request
        n = 0;
        while (count != 3'd4 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        check("full_count", 64'(count), 64'd4);
        check("full_req_total", 64'(req_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("full_req_addr", 64'(log_at(i)), 64'(4 * i));
        end

        // One pop frees a slot, then pop and completion land on the same edge
        pop_one();
        check("pop1_count", 64'(count), 64'd3);
        n = 0;
        while (!mem_req && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("fifth_req", 64'(mem_req), 64'd1);
        check("fifth_addr", 64'(mem_addr), 64'h10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_simul_count", 64'(count), 64'd3);
        e = '{instr: word_of(32'h4), pc: 32'h4};
        exp_q.push_back(e);
        pop_one();
        check("simul_count", 64'(count), 64'd3);
        check("simul_head_pc", 64'(pc_out), 64'h8);
        check("simul_head_instr", 64'(instr_out), 64'h00100093);

        // Refill, then redirect while IDLE and full; addr 8 first returns the sentinel
        n = 0;
        while (count != 3'd4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("refill_count", 64'(count), 64'd4);
        check("wrap_head_pc", 64'(pc_out), 64'h8);
        inv_target  = 1;
        redirect    = 1'b1;
        redirect_pc = 32'h8;
        @(posedge clk); #1;
        redirect = 1'b0;
        check("redir_idle_count", 64'(count), 64'd0);
        check("redir_idle_valid", 64'(instr_valid), 64'd0);
        check("redir_idle_noreq", 64'(mem_req), 64'd0);
        base = req_log.size();
        @(posedge clk); #1;
        check("redir_idle_req", 64'(mem_req), 64'd1);
        check("redir_idle_addr", 64'(mem_addr), 64'h8);
        n = 0;
        while (!instr_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("inv_req0", 64'(log_at(base)), 64'h8);
        check("inv_req1", 64'(log_at(base + 1)), 64'h8);
        check("inv_instr", 64'(instr_out), 64'h00100093);
        check("inv_pc", 64'(pc_out), 64'h8);
        check("inv_count", 64'(count), 64'd1);
        e = '{instr: 32'h00100093, pc: 32'h8};
        exp_q.push_back(e);
        pop_one();

        // Redirect to 0x40 while the 0x10 request is outstanding
        n = 0;
        while (!(mem_req && mem_addr == 32'h10) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait10_req", 64'(mem_req), 64'd1);
        check("wait10_count", 64'(count), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(posedge clk); #1;
        redirect = 1'b0;
        check("redir_wait_count", 64'(count), 64'd0);
        check("redir_wait_valid", 64'(instr_valid), 64'd0);
        base = req_log.size();
        n = 0;
        while (!instr_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("redir_wait_req", 64'(log_at(base)), 64'h40);
        check("redir_wait_pc", 64'(pc_out), 64'h40);
        check("redir_wait_instr", 64'(instr_out), 64'h00040013);
        check("redir_wait_cnt1", 64'(count), 64'd1);

        // Reset during WAIT with one entry queued
        n = 0;
        while (!mem_req && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_rst_addr", 64'(mem_addr), 64'h44);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("arst_mem_req", 64'(mem_req), 64'd0);
        check("arst_mem_addr", 64'(mem_addr), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid", 64'(instr_valid), 64'd0);
        check("arst_instr", 64'(instr_out), 64'd0);
        check("arst_pc", 64'(pc_out), 64'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        base = req_log.size();
        @(posedge clk); #1;
        check("post_rst_req", 64'(mem_req), 64'd1);
        check("post_rst_addr", 64'(mem_addr), 64'd0);
        e = '{instr: 32'h13, pc: 32'h0};
        exp_q.push_back(e);
        n = 0;
        while (!instr_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        pop_one();
        @(negedge clk);
        #1;
        check("post_rst_log", 64'(log_at(base)), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/t07_fetch_queue.md
T07_FETCH_QUEUE -- requirements
Module: t07_fetch_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 32, program counter width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have parameter INVALID_WORD, default 32'hDEADBEEF, sentinel marking a non-instruction return.
REQ-006 SHALL have ports: clk  in  1  clock; nrst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: mem_req  out  1  one-cycle fetch request pulse; mem_addr  out  ADDR_W  fetch address, held stable until completion.
REQ-008 SHALL have ports: mem_busy  in  1  memory busy; mem_rdata  in  DATA_W  returned word, valid in the completion cycle.
REQ-009 SHALL have ports: redirect  in  1  flush and restart request; redirect_pc  in  ADDR_W  restart address.
REQ-010 SHALL have ports: instr_ready  in  1  consumer pop; instr_valid  out  1  head entry valid; instr_out  out  DATA_W  head instruction; pc_out  out  ADDR_W  head address; count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, DRAIN.
REQ-012 SHALL define completion as a cycle with mem_busy=0 whose registered previous mem_busy was 1.
REQ-013 IDLE: when count < DEPTH and no redirect, SHALL pulse mem_req for one cycle with mem_addr = fetch_pc and go to WAIT.
REQ-014 WAIT: on completion with mem_rdata != INVALID_WORD, SHALL push {mem_rdata, mem_addr}, advance fetch_pc by 4 (mod 2^ADDR_W), return to IDLE.
REQ-015 WAIT: on completion with mem_rdata == INVALID_WORD, SHALL push nothing, keep fetch_pc, return to IDLE (same address re-requested).
REQ-016 At most one request SHALL be outstanding; a push SHALL never occur when count == DEPTH.
REQ-017 Queue SHALL be show-ahead: instr_valid = (count != 0); instr_out/pc_out show the head entry, both 0 when empty.
REQ-018 instr_valid & instr_ready SHALL pop the head in that cycle; instr_ready while empty SHALL be ignored.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH.
REQ-021 redirect in IDLE SHALL empty the queue (count=0 next cycle), set fetch_pc = redirect_pc, and issue no request that cycle.
REQ-022 redirect in WAIT SHALL empty the queue, set fetch_pc = redirect_pc, go to DRAIN.
REQ-023 DRAIN SHALL discard the next completion's data without pushing, then go to IDLE; redirect in DRAIN only updates fetch_pc.
REQ-024 redirect coinciding with completion SHALL discard that response; redirect SHALL override a same-cycle pop.
REQ-025 Minimum latency request-to-instr_valid SHALL be one cycle after the completion cycle.

Reset
REQ-026 nrst low SHALL asynchronously force: state IDLE, fetch_pc = RESET_PC, mem_req 0, mem_addr RESET_PC, count 0, instr_valid 0, instr_out 0, pc_out 0, previous-busy register 0, pointers 0.
REQ-027 Reset mid-transaction SHALL abandon it; the first mem_req after release SHALL be to RESET_PC, in the first clock edge after release.

Verification
REQ-028 Reset release, memory returns 0x00000013 for addr 0 after 2 busy cycles -> mem_req at addr 0, instr_valid=1, instr_out=0x13, pc_out=0 the cycle after completion.
REQ-029 Consumer held off, DEPTH=4 -> exactly 4 requests (addr 0,4,8,12), count=4, no fifth mem_req until one pop.
REQ-030 Memory returns 0xDEADBEEF at addr 8 then 0x00100093 -> addr 8 requested twice, only 0x00100093 enqueued with pc_out=8.
REQ-031 redirect to 0x40 while a request to 0x10 is in WAIT -> queue empties, 0x10 response dropped, next mem_req addr 0x40, first instr_valid has pc_out=0x40.
REQ-032 Queue full with pop and completion in same cycle after one pop frees a slot -> count stays constant, order preserved across pointer wrap.
REQ-033 nrst asserted during WAIT -> all outputs zero immediately, first post-reset mem_req to RESET_PC.
